// File: rtl/regression_pkg.sv
// Shared widths and FSM encoding for the linear-regression datapath.
// The coefficient stage reuses these widths.
package regression_pkg;

  localparam int DATA_W     = 8;
  localparam int EXT_W      = 8;
  localparam int SUM_W      = DATA_W + EXT_W;
  localparam int PROD_SUM_W = 2 * DATA_W + EXT_W;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/regression_sum_accumulator_if.sv
// Counter control, sample data and running-sum bundle for the sum accumulator.
// The accumulator side uses master; the counter/memory side uses slave. ACC_SUM_YY_EN adds sum_yy.
interface regression_sum_accumulator_if #(
  parameter int DATA_W = regression_pkg::DATA_W,
  parameter int EXT_W  = regression_pkg::EXT_W
);

  logic                              start;
  logic                              cnt_clr;
  logic                              cnt_en;
  logic                              cnt_cout;
  logic signed [DATA_W-1:0]          x_in;
  logic signed [DATA_W-1:0]          y_in;
  logic                              busy;
  logic                              done;
  logic signed [DATA_W+EXT_W-1:0]    sum_x;
  logic signed [DATA_W+EXT_W-1:0]    sum_y;
  logic signed [2*DATA_W+EXT_W-1:0]  sum_xx;
  logic signed [2*DATA_W+EXT_W-1:0]  sum_xy;
`ifdef ACC_SUM_YY_EN
  logic signed [2*DATA_W+EXT_W-1:0]  sum_yy;
`endif

  modport master (
    input  start, cnt_cout, x_in, y_in,
    output cnt_clr, cnt_en, busy, done, sum_x, sum_y, sum_xx, sum_xy
`ifdef ACC_SUM_YY_EN
    , output sum_yy
`endif
  );

  modport slave (
    output start, cnt_cout, x_in, y_in,
    input  cnt_clr, cnt_en, busy, done, sum_x, sum_y, sum_xx, sum_xy
`ifdef ACC_SUM_YY_EN
    , input sum_yy
`endif
  );

endinterface

// File: rtl/signed_accumulator.sv
// Two's-complement running sum: clear wins over add, wraps without saturation.
// One-cycle update; always accepts the operand when add_en is high.
module signed_accumulator #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                add_en,
  input  logic signed [W-1:0] operand,
  output logic signed [W-1:0] sum
);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + operand;
    end
  end

endmodule

// File: rtl/regression_sum_accumulator.sv
// Sequences one pass of the modulo counter and accumulates sum x, y, xx, xy (plus yy with ACC_SUM_YY_EN).
// Pass takes N+3 cycles from start to done; start is ignored while busy, no backpressure on samples.
module regression_sum_accumulator #(
  parameter int DATA_W = regression_pkg::DATA_W,
  parameter int EXT_W  = regression_pkg::EXT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  regression_sum_accumulator_if.master  bus
);

  import regression_pkg::*;

  localparam int ACC_W  = DATA_W + EXT_W;
  localparam int PROD_W = 2 * DATA_W;
  localparam int PACC_W = PROD_W + EXT_W;

  state_t state;
  state_t state_nxt;
  logic   sample_vld;
  logic   acc_clr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bus.busy    = 1'b1;
    bus.cnt_en  = 1'b0;
    bus.cnt_clr = 1'b0;
    bus.done    = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nxt = CLR;
      end
      CLR: begin
        bus.cnt_clr = 1'b1;
        state_nxt   = RUN;
      end
      RUN: begin
        bus.cnt_en = 1'b1;
        if (bus.cnt_cout) state_nxt = DRAIN;
      end
      DRAIN: begin
        state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Memory data lags its address by one cycle, so validity is cnt_en delayed.
  always_ff @(posedge clk) begin
    if (!rst || state == CLR) begin
      sample_vld <= 1'b0;
    end else begin
      sample_vld <= bus.cnt_en;
    end
  end

  assign acc_clr = (state == CLR);

  logic signed [PROD_W-1:0] xx_p;
  logic signed [PROD_W-1:0] xy_p;
  logic signed [ACC_W-1:0]  acc_x;
  logic signed [ACC_W-1:0]  acc_y;
  logic signed [PACC_W-1:0] acc_xx;
  logic signed [PACC_W-1:0] acc_xy;

  assign xx_p = PROD_W'(bus.x_in) * PROD_W'(bus.x_in);
  assign xy_p = PROD_W'(bus.x_in) * PROD_W'(bus.y_in);

  signed_accumulator #(.W(ACC_W)) u_acc_x (
    .clk(clk), .rst(rst), .clear(acc_clr), .add_en(sample_vld),
    .operand(ACC_W'(bus.x_in)), .sum(acc_x)
  );

  signed_accumulator #(.W(ACC_W)) u_acc_y (
    .clk(clk), .rst(rst), .clear(acc_clr), .add_en(sample_vld),
    .operand(ACC_W'(bus.y_in)), .sum(acc_y)
  );

  signed_accumulator #(.W(PACC_W)) u_acc_xx (
    .clk(clk), .rst(rst), .clear(acc_clr), .add_en(sample_vld),
    .operand(PACC_W'(xx_p)), .sum(acc_xx)
  );

  signed_accumulator #(.W(PACC_W)) u_acc_xy (
    .clk(clk), .rst(rst), .clear(acc_clr), .add_en(sample_vld),
    .operand(PACC_W'(xy_p)), .sum(acc_xy)
  );

  assign bus.sum_x  = acc_x;
  assign bus.sum_y  = acc_y;
  assign bus.sum_xx = acc_xx;
  assign bus.sum_xy = acc_xy;

`ifdef ACC_SUM_YY_EN
  logic signed [PROD_W-1:0] yy_p;
  logic signed [PACC_W-1:0] acc_yy;

  assign yy_p = PROD_W'(bus.y_in) * PROD_W'(bus.y_in);

  signed_accumulator #(.W(PACC_W)) u_acc_yy (
    .clk(clk), .rst(rst), .clear(acc_clr), .add_en(sample_vld),
    .operand(PACC_W'(yy_p)), .sum(acc_yy)
  );

  assign bus.sum_yy = acc_yy;
`endif

endmodule

// File: tb/tb_regression_sum_accumulator.sv
// Bench for regression_sum_accumulator: emulates the modulo counter and 1-cycle sample memory,
// and checks every cycle against a pass-level model built from the timing and sum rules.
module tb_regression_sum_accumulator;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;

  regression_sum_accumulator_if bus ();

  regression_sum_accumulator dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Counter + memory emulation
  logic signed [7:0] mem_x [256];
  logic signed [7:0] mem_y [256];
  int   n_mod;
  int   cnt;
  logic spur;
  logic en_s;
  logic clr_s;

  assign bus.cnt_cout = (cnt == n_mod - 1) || spur;

  initial begin
    logic [31:0] r;
    cnt      = 0;
    bus.x_in = '0;
    bus.y_in = '0;
    forever begin
      @(negedge clk);
      en_s  = (bus.cnt_en === 1'b1);
      clr_s = (bus.cnt_clr === 1'b1);
      @(posedge clk);
      #1;
      if (en_s) begin
        bus.x_in = mem_x[cnt];
        bus.y_in = mem_y[cnt];
      end else begin
        r = $urandom;
        bus.x_in = r[7:0];
        bus.y_in = r[15:8];
      end
      if (clr_s) cnt = 0;
      else if (en_s) cnt = (cnt == n_mod - 1) ? 0 : cnt + 1;
    end
  end

  // Pass-level model: phase = cycles since the start edge (0 = idle)
  int phase;
  int m_sx, m_sy, m_sxx, m_sxy, m_syy;

  initial begin
    int xi, yi;
    phase = 0;
    m_sx = 0; m_sy = 0; m_sxx = 0; m_sxy = 0; m_syy = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("busy",    bus.busy,    phase != 0);
      chk("cnt_clr", bus.cnt_clr, phase == 1);
      chk("cnt_en",  bus.cnt_en,  phase >= 2 && phase <= n_mod + 1);
      chk("done",    bus.done,    phase == n_mod + 3);
      if (phase == 0 || phase == 1 || phase == n_mod + 3) begin
        chk("sum_x",  bus.sum_x,  m_sx);
        chk("sum_y",  bus.sum_y,  m_sy);
        chk("sum_xx", bus.sum_xx, m_sxx);
        chk("sum_xy", bus.sum_xy, m_sxy);
`ifdef ACC_SUM_YY_EN
        chk("sum_yy", bus.sum_yy, m_syy);
`endif
      end
      if (rst !== 1'b1) begin
        phase = 0;
        m_sx = 0; m_sy = 0; m_sxx = 0; m_sxy = 0; m_syy = 0;
      end else if (phase == 0) begin
        if (bus.start === 1'b1) phase = 1;
      end else if (phase == n_mod + 3) begin
        phase = 0;
      end else begin
        phase++;
        if (phase == n_mod + 3) begin
          m_sx = 0; m_sy = 0; m_sxx = 0; m_sxy = 0; m_syy = 0;
          for (int i = 0; i < n_mod; i++) begin
            xi = int'(mem_x[i]);
            yi = int'(mem_y[i]);
            m_sx  += xi;
            m_sy  += yi;
            m_sxx += xi * xi;
            m_sxy += xi * yi;
            m_syy += yi * yi;
          end
        end
      end
    end
  end

  task automatic fill(input int xv, input int yv);
    for (int i = 0; i < 256; i++) begin
      mem_x[i] = 8'(xv);
      mem_y[i] = 8'(yv);
    end
  endtask

  task automatic fill_rand();
    logic [31:0] r;
    for (int i = 0; i < 256; i++) begin
      r = $urandom;
      mem_x[i] = r[7:0];
      mem_y[i] = r[15:8];
    end
  endtask

  task automatic start_pass(output int c0);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        at = cyc;
        break;
      end
    end
    chk("done_seen", at >= 0, 1);
  endtask

  task automatic chk_sums(input string tag, input int sx, input int sy, input int sxx,
                          input int sxy, input int syy);
    chk({tag, "_sum_x"},  bus.sum_x,  sx);
    chk({tag, "_sum_y"},  bus.sum_y,  sy);
    chk({tag, "_sum_xx"}, bus.sum_xx, sxx);
    chk({tag, "_sum_xy"}, bus.sum_xy, sxy);
`ifdef ACC_SUM_YY_EN
    chk({tag, "_sum_yy"}, bus.sum_yy, syy);
`else
    if (syy != 0) begin end
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, td, td2, ndone;
    errors    = 0;
    checks    = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    spur      = 1'b0;
    n_mod     = 150;
    fill(1, 2);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Constant samples; done must land N+3 cycles after start
    start_pass(c0);
    wait_done(400, td);
    chk("A_latency", td - c0, 153);
    chk_sums("A", 150, 300, 150, 300, 600);

    // Spurious terminal count during DONE and the following IDLE cycles
    spur = 1'b1;
    repeat (3) @(posedge clk);
    #1 spur = 1'b0;
    @(negedge clk);
    chk("spur_busy", bus.busy, 0);
    chk_sums("spur", 150, 300, 150, 300, 600);

    // Signed samples
    fill(-1, 3);
    start_pass(c0);
    wait_done(400, td);
    chk_sums("B", -150, 450, 150, -450, 1350);

    // Extremes
    fill(-128, 127);
    start_pass(c0);
    wait_done(400, td);
    chk_sums("C", -19200, 19050, 2457600, -2438400, 2419350);

    // Random data, short modulus
    @(posedge clk);
    #1 n_mod = 37;
    fill_rand();
    start_pass(c0);
    wait_done(100, td);
    chk("R_latency", td - c0, 40);

    // start held high: passes run back to back, second restarts from zero
    @(posedge clk);
    #1 n_mod = 5;
    fill(2, -3);
    bus.start = 1'b1;
    wait_done(50, td);
    chk_sums("H1", 10, -15, 20, -30, 45);
    fill(5, 7);
    wait_done(50, td2);
    chk("H_gap", td2 - td, 9);
    chk_sums("H2", 25, 35, 125, 175, 245);
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("H_idle", bus.busy, 0);

    // Reset in RUN cycle 40
    @(posedge clk);
    #1 n_mod = 150;
    fill(1, 2);
    start_pass(c0);
    repeat (40) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_busy",   bus.busy,   0);
    chk("rst_cnt_en", bus.cnt_en, 0);
    chk_sums("rst", 0, 0, 0, 0, 0);
    ndone = 0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    chk("rst_no_done", ndone, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regression_sum_accumulator.md
# regression_sum_accumulator

Downstream consumer of the 8-bit modulo sample counter in the linear-regression datapath. Sequences one pass over the sample memory by enabling and clearing the counter. Consumes each (x, y) sample returned by the synchronous sample memory, which is addressed by the counter output. Produces the four running sums (Σx, Σy, Σxx, Σxy) that the coefficient-calculation stage needs.

## Interface
- DATA_W, 8, signed width of x and y samples
- EXT_W, 8, guard bits added to every accumulator; covers up to 256 samples

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- start  in  1  request one accumulation pass; sampled only in IDLE
- cnt_clr  out  1  active-high clear to the modulo counter
- cnt_en  out  1  count enable to the modulo counter; also means "memory address valid this cycle"
- cnt_cout  in  1  counter terminal-count flag (counter output = modulus-1)
- x_in  in  DATA_W  signed sample x; memory read data, one cycle after its address
- y_in  in  DATA_W  signed sample y; same timing as x_in
- busy  out  1  high in every state except IDLE
- done  out  1  single-cycle pulse; sums are final and stable
- sum_x, sum_y  out  DATA_W+EXT_W  signed Σx, Σy
- sum_xx, sum_xy  out  2*DATA_W+EXT_W  signed Σx², Σx·y

## Operation
- FSM states: IDLE, CLR, RUN, DRAIN, DONE.
- IDLE
  - busy=0, cnt_en=0, cnt_clr=0.
  - start=1 → CLR.
- CLR (1 cycle)
  - cnt_clr=1.
  - All sums and the internal sample-valid flag are cleared at the clock edge.
  - → RUN.
- RUN
  - cnt_en=1.
  - sample-valid register = registered copy of cnt_en.
  - When cnt_cout=1 in RUN, the last address is being issued this cycle → DRAIN.
- DRAIN (1 cycle)
  - cnt_en=0.
  - Last sample is accumulated.
  - → DONE.
- DONE (1 cycle)
  - done=1.
  - → IDLE.
- Accumulation rule: when sample-valid=1, every sum adds its term at the clock edge.
  - x and y are sign-extended.
  - Products are full 2*DATA_W signed, then sign-extended.
  - Wrap-around is two's complement with no saturation; EXT_W guarantees no overflow for ≤256 samples.
- Sums hold their values from DONE until the next CLR.
- Boundary conditions:
  - start while busy: ignored.
  - cnt_cout=1 outside RUN: ignored.
  - rst=0 at any time, including mid-pass: next edge forces IDLE, all sums=0, sample-valid=0.
  - Outputs after reset: busy=0, done=0, cnt_en=0, cnt_clr=0, all sums=0.

## Timing
- start sampled high at edge k.
  - CLR occupies cycle k+1.
  - RUN occupies cycles k+2 … k+N+1, where N = counter modulus.
  - DRAIN occupies cycle k+N+2.
  - DONE (done=1) occupies cycle k+N+3.
- Memory latency is fixed at 1 cycle.
  - Data for the address issued in cycle t is presented in cycle t+1.
  - That data is accumulated at the end of cycle t+1.
- The first RUN cycle accumulates nothing.
- Total pass length is N+3 cycles from start to done.
- Back-to-back passes: start may be asserted in the cycle after DONE (IDLE); the minimum gap is 1 cycle.

## Configuration
- ACC_SUM_YY_EN
  - Defined: adds output port sum_yy (2*DATA_W+EXT_W, signed Σy²), accumulated and cleared exactly like sum_xx. Used for the R² computation.
  - Undefined: no sum_yy port, and no y-squared multiplier or register.

## Structure
- Shared package regression_pkg holds:
  - the FSM state typedef (IDLE, CLR, RUN, DRAIN, DONE);
  - DATA_W/EXT_W defaults and derived width constants (SUM_W, PROD_SUM_W), reused by the coefficient stage.
- Sub-module signed_accumulator
  - Parameterised width.
  - Inputs: clear, add_en, operand.
  - Instantiated 4 times, or 5 with ACC_SUM_YY_EN.
- FSM and the sample-valid pipeline register live in the top.

## Test plan
- Reset mid-pass:
  - Stimulus: rst=0 for 1 cycle at RUN cycle 40.
  - Response: next cycle busy=0, cnt_en=0, all sums=0, and no done pulse.
- Constant samples, N=150, x=1, y=2:
  - Response: done exactly 153 cycles after start.
  - sum_x=150, sum_y=300, sum_xx=150, sum_xy=300.
- Signed samples, N=150, x=-1, y=3:
  - sum_x=-150, sum_y=450, sum_xx=150, sum_xy=-450.
  - With ACC_SUM_YY_EN: sum_yy=1350.
- Extremes, N=150, x=-128, y=127:
  - sum_x=-19200, sum_xx=2457600, sum_xy=-2438400, with no overflow.
- start held high through an entire pass:
  - Only one pass runs during busy.
  - A second pass begins in the cycle after DONE, and its sums restart from 0 after CLR.
- Spurious cnt_cout=1 during IDLE and DONE:
  - No state change, no accumulation, and sums unchanged.
